dlx_inst_sequencer: RTL and testbench
=====================================

Name: dlx_inst_sequencer

Overview:
- Parametrised, synthesizable instruction-stream sequencer that replaces hand-timed stimulus for the DLX pipeline.
- Holds a loadable program memory in which each entry carries its own hold count.
- On start it drives the core's reset pulse, issues every entry for its programmed number of cycles, and pads with NOPs through a drain window.
- It sits between the harness and dlxpipeline's reset and inst_in, and reports completion and elapsed cycles.

Parameters:
DATA_W, 32, instruction width
DEPTH, 64, program memory entries
ADDR_W, 6, log2(DEPTH)
HOLD_W, 4, per-entry hold field width
RST_CYCLES, 4, cycles core_reset_n is held low after start (>=1)
DRAIN_CYCLES, 16, NOP cycles after the last entry (>=1)
NOP_WORD, 32'h0000_0000, word driven when not issuing

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
load_en  in  1  write strobe for program memory
load_addr  in  ADDR_W  write address
load_data  in  DATA_W  instruction to store
load_hold  in  HOLD_W  hold count minus 1 (0 = 1 cycle)
prog_len  in  ADDR_W+1  number of entries to issue, sampled on start
start  in  1  single-cycle run request
abort  in  1  stops the run immediately
core_reset_n  out  1  active-low reset to the core
inst_o  out  DATA_W  instruction to the core
inst_valid  out  1  inst_o is a program entry, not padding
inst_idx  out  ADDR_W  index of the entry being issued
busy  out  1  run in progress
done  out  1  run completed; level signal
cycle_cnt  out  32  cycles since core reset release in the current run

Behaviour:
- Reset (reset=0, async) forces the following:
  - state IDLE, core_reset_n=0, inst_o=NOP_WORD, inst_valid=0, inst_idx=0, busy=0, done=0, cycle_cnt=0.
  - Memory contents are not cleared.
- Memory:
  - Each entry is {hold, instr}, one write port and one read port.
  - A write occurs on an edge with load_en=1 and busy=0. Writes while busy are ignored.
- States: IDLE, RST, ISSUE, DRAIN, DONE. All outputs are registered.
- IDLE/DONE + start:
  - Capture len = min(prog_len, DEPTH).
  - Clear done and cycle_cnt; set busy=1.
  - Enter RST with core_reset_n=0. start while busy is ignored.
- RST:
  - core_reset_n stays 0 for exactly RST_CYCLES cycles.
  - Then core_reset_n=1 and enter ISSUE, or enter DRAIN if len=0.
- ISSUE:
  - In the first cycle after RST: inst_o=mem[0].instr, inst_valid=1, inst_idx=0.
  - Entry i is driven for mem[i].hold+1 consecutive cycles, then entry i+1.
  - After entry len-1 completes, enter DRAIN.
- DRAIN: inst_o=NOP_WORD, inst_valid=0, for DRAIN_CYCLES cycles, then enter DONE.
- DONE:
  - busy=0, done=1, core_reset_n stays 1 so core state remains observable.
  - inst_o=NOP_WORD. done holds until the next start or reset.
- cycle_cnt:
  - Increments each cycle that busy=1 and core_reset_n=1; saturates at 32'hFFFF_FFFF.
  - Frozen in IDLE/DONE.
- abort (any busy state):
  - Next edge: IDLE, core_reset_n=0, inst_o=NOP_WORD, inst_valid=0, busy=0, done=0.
  - cycle_cnt is frozen.
  - abort and start on the same edge: abort wins and start is dropped.
- load and start on the same edge in IDLE: the write completes. The first read happens at least RST_CYCLES later, so the new data is issued.
- Memory wrap-around:
  - inst_idx never exceeds len-1; there is no wrap.
  - prog_len>DEPTH is clamped to DEPTH.
- Total run length from the start edge to done=1 is RST_CYCLES + sum(hold_i+1) + DRAIN_CYCLES cycles (+1 registration edge).

Test Plan:
- Reset and idle:
  - Stimulus: reset low mid-ISSUE.
  - Required: all outputs at reset values immediately (async). After release, state is IDLE and the previous program re-runs on start.
- Basic run:
  - Stimulus: load 2 entries (ADDI R1,R2,15 with hold=0; ADDI R2,R3,15 with hold=4), prog_len=2, start.
  - Required: core_reset_n low 4 cycles.
  - Required: 0x4022000F for 1 cycle, then 0x4043000F for 5 cycles (inst_idx 0 then 1).
  - Required: 16 NOP cycles, then done=1 with cycle_cnt=22.
- Empty program:
  - Stimulus: prog_len=0, start.
  - Required: RST 4 cycles, DRAIN 16 cycles, done=1, inst_valid never asserted.
- Abort and stray controls:
  - Stimulus: abort in the 3rd ISSUE cycle.
  - Required: next cycle core_reset_n=0, busy=0, done=0.
  - Stimulus: a start pulse during a busy run.
  - Required: ignored, no restart.
- Clamp and load lockout:
  - Stimulus: prog_len=100 with DEPTH=64.
  - Required: exactly 64 entries issued, inst_idx max 63.
  - Stimulus: load_en while busy.
  - Required: memory unchanged, verified by a re-run.
- Simultaneous events:
  - Stimulus: start and abort on the same edge.
  - Required: stays IDLE.
  - Stimulus: load mem[0] and start on the same edge.
  - Required: the new word is issued first.

Source files
------------

// File: rtl/dlx_inst_sequencer_if.sv
// Harness-side bus of the DLX instruction sequencer:
// program load port, run controls and the core-facing stream.
interface dlx_inst_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter int HOLD_W = 4
);
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic [HOLD_W-1:0] load_hold;
  logic [ADDR_W:0]   prog_len;
  logic              start;
  logic              abort;
  logic              core_reset_n;
  logic [DATA_W-1:0] inst_o;
  logic              inst_valid;
  logic [ADDR_W-1:0] inst_idx;
  logic              busy;
  logic              done;
  logic [31:0]       cycle_cnt;

  modport master (
    output load_en, load_addr, load_data, load_hold,
    output prog_len, start, abort,
    input  core_reset_n, inst_o, inst_valid, inst_idx,
    input  busy, done, cycle_cnt
  );

  modport slave (
    input  load_en, load_addr, load_data, load_hold,
    input  prog_len, start, abort,
    output core_reset_n, inst_o, inst_valid, inst_idx,
    output busy, done, cycle_cnt
  );
endinterface

// File: rtl/dlx_inst_sequencer.sv
// Replays a loaded program into the DLX core: reset pulse,
// per-entry hold counts, NOP drain, then a completion level.
module dlx_inst_sequencer #(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 64,
  parameter int ADDR_W       = 6,
  parameter int HOLD_W       = 4,
  parameter int RST_CYCLES   = 4,
  parameter int DRAIN_CYCLES = 16,
  parameter logic [DATA_W-1:0] NOP_WORD = 32'h0000_0000
) (
  input logic             clock,
  input logic             reset,
  dlx_inst_sequencer_if.slave bus
);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [ADDR_W-1:0] IDX_ONE = 1;
  localparam logic [ADDR_W:0]   LEN_ONE = 1;
  localparam logic [ADDR_W:0]   DEPTH_L = DEPTH;

  typedef enum logic [2:0] {
    IDLE, RST, ISSUE, DRAIN, DONE
  } state_t;

  state_t              state;
  logic [ADDR_W:0]     len;
  logic [HOLD_W-1:0]   hcnt;
  logic [RW-1:0]       rcnt;
  logic [DW-1:0]       dcnt;
  logic [HOLD_W+DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0]   nidx;
  logic [HOLD_W-1:0]   nhold;
  logic [DATA_W-1:0]   ninst;
  logic [ADDR_W:0]     clen;
  logic                last;

  always_ff @(posedge clock) begin
    if (bus.load_en && !bus.busy)
      mem[bus.load_addr] <= {bus.load_hold, bus.load_data};
  end

  // Next entry to present: entry 0 leaving RST, else the successor.
  assign nidx = (state == ISSUE) ? bus.inst_idx + IDX_ONE : '0;
  assign {nhold, ninst} = mem[nidx];
  assign clen = (bus.prog_len > DEPTH_L) ? DEPTH_L : bus.prog_len;
  assign last = ({1'b0, bus.inst_idx} == len - LEN_ONE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      len              <= '0;
      hcnt             <= '0;
      rcnt             <= '0;
      dcnt             <= '0;
      bus.core_reset_n <= 1'b0;
      bus.inst_o       <= NOP_WORD;
      bus.inst_valid   <= 1'b0;
      bus.inst_idx     <= '0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.cycle_cnt    <= '0;
    end else begin
      if (bus.busy && bus.core_reset_n && !bus.abort &&
          bus.cycle_cnt != '1)
        bus.cycle_cnt <= bus.cycle_cnt + 32'd1;

      if (bus.abort && bus.busy) begin
        state            <= IDLE;
        bus.core_reset_n <= 1'b0;
        bus.inst_o       <= NOP_WORD;
        bus.inst_valid   <= 1'b0;
        bus.busy         <= 1'b0;
        bus.done         <= 1'b0;
      end else begin
        unique case (state)
          IDLE, DONE: begin
            if (bus.start && !bus.abort) begin
              state            <= RST;
              len              <= clen;
              rcnt             <= RW'(RST_CYCLES - 1);
              bus.core_reset_n <= 1'b0;
              bus.inst_o       <= NOP_WORD;
              bus.inst_valid   <= 1'b0;
              bus.busy         <= 1'b1;
              bus.done         <= 1'b0;
              bus.cycle_cnt    <= '0;
            end
          end
          RST, ISSUE: begin
            if (state == RST && rcnt != '0) begin
              rcnt <= rcnt - 1'b1;
            end else if (state == ISSUE && hcnt != '0) begin
              hcnt <= hcnt - 1'b1;
            end else if ((state == RST && len == '0) ||
                         (state == ISSUE && last)) begin
              state            <= DRAIN;
              dcnt             <= DW'(DRAIN_CYCLES - 1);
              bus.core_reset_n <= 1'b1;
              bus.inst_o       <= NOP_WORD;
              bus.inst_valid   <= 1'b0;
            end else begin
              state            <= ISSUE;
              hcnt             <= nhold;
              bus.core_reset_n <= 1'b1;
              bus.inst_o       <= ninst;
              bus.inst_valid   <= 1'b1;
              bus.inst_idx     <= nidx;
            end
          end
          DRAIN: begin
            if (dcnt != '0) begin
              dcnt <= dcnt - 1'b1;
            end else begin
              state    <= DONE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dlx_inst_sequencer.sv
// Self-checking bench for dlx_inst_sequencer: a trace model
// built from the run rules, table vectors and corner sequences.
module tb_dlx_inst_sequencer;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int HOLD_W = 4;
  localparam int RSTC   = 4;
  localparam int DRAINC = 16;
  localparam logic [31:0] NOP = 32'h0;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  dlx_inst_sequencer_if #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .HOLD_W(HOLD_W)
  ) bus ();

  dlx_inst_sequencer #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .HOLD_W(HOLD_W), .RST_CYCLES(RSTC),
    .DRAIN_CYCLES(DRAINC), .NOP_WORD(NOP)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  typedef struct packed {
    logic        crn;
    logic [31:0] inst;
    logic        valid;
    logic [5:0]  idx;
    logic        busy;
    logic        done;
    logic [31:0] cnt;
  } obs_t;

  typedef struct {
    logic [6:0] plen;
    int         cnt;
    int         nvalid;
    int         maxidx;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [35:0] mem_m [DEPTH];
  obs_t obs [512];
  int n_valid, max_idx;
  logic [31:0] last_cnt;

  function automatic obs_t mk(logic c, logic [31:0] i, logic v,
                              logic [5:0] x, logic b, logic d,
                              logic [31:0] n);
    obs_t o;
    o.crn = c; o.inst = i; o.valid = v; o.idx = x;
    o.busy = b; o.done = d; o.cnt = n;
    return o;
  endfunction

  function automatic obs_t sample();
    return mk(bus.core_reset_n, bus.inst_o, bus.inst_valid,
              bus.inst_idx, bus.busy, bus.done, bus.cycle_cnt);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_obs(string name, obs_t got, obs_t exp,
                           bit care_idx);
    checks++;
    if (!care_idx) begin
      got.idx = '0;
      exp.idx = '0;
    end
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got crn=%b inst=%h v=%b idx=%0d busy=%b done=%b cnt=%0d want crn=%b inst=%h v=%b idx=%0d busy=%b done=%b cnt=%0d",
               name, got.crn, got.inst, got.valid, got.idx, got.busy,
               got.done, got.cnt, exp.crn, exp.inst, exp.valid,
               exp.idx, exp.busy, exp.done, exp.cnt);
    end
  endtask

  task automatic check_val(string name, logic [63:0] got,
                           logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic load(int a, logic [31:0] d, logic [3:0] h);
    bus.load_en   = 1'b1;
    bus.load_addr = a[5:0];
    bus.load_data = d;
    bus.load_hold = h;
    tick();
    bus.load_en = 1'b0;
    mem_m[a] = {h, d};
  endtask

  // Expected trace: RST low window, each entry repeated hold+1
  // times, NOP drain, then a couple of DONE cycles.
  task automatic run_prog(input logic [6:0] plen, input int s_at,
                          input int l_at, input bit ld0,
                          input logic [31:0] ld_data,
                          input logic [3:0] ld_hold);
    obs_t q[$];
    obs_t got;
    int L, n;
    if (ld0) mem_m[0] = {ld_hold, ld_data};
    L = (int'(plen) > DEPTH) ? DEPTH : int'(plen);
    n = 0;
    for (int k = 0; k < RSTC; k++)
      q.push_back(mk(0, NOP, 0, 0, 1, 0, 0));
    for (int i = 0; i < L; i++)
      for (int h = 0; h <= int'(mem_m[i][35:32]); h++) begin
        q.push_back(mk(1, mem_m[i][31:0], 1, i[5:0], 1, 0, n));
        n++;
      end
    for (int d = 0; d < DRAINC; d++) begin
      q.push_back(mk(1, NOP, 0, 0, 1, 0, n));
      n++;
    end
    for (int d = 0; d < 2; d++)
      q.push_back(mk(1, NOP, 0, 0, 0, 1, n));

    bus.prog_len = plen;
    bus.start = 1'b1;
    if (ld0) begin
      bus.load_en   = 1'b1;
      bus.load_addr = '0;
      bus.load_data = ld_data;
      bus.load_hold = ld_hold;
    end
    n_valid = 0;
    max_idx = 0;
    for (int k = 0; k < q.size(); k++) begin
      tick();
      bus.start   = (k + 1 == s_at);
      bus.load_en = (k + 1 == l_at);
      bus.load_addr = 6'd2;
      bus.load_data = 32'hDEAD_BEEF;
      bus.load_hold = 4'd7;
      got = sample();
      if (k < 512) obs[k] = got;
      if (got.valid === 1'b1) begin
        n_valid++;
        if (int'(got.idx) > max_idx) max_idx = int'(got.idx);
      end
      last_cnt = got.cnt;
      check_obs($sformatf("run_len%0d_cyc%0d", plen, k), got, q[k],
                q[k].valid);
    end
    bus.start   = 1'b0;
    bus.load_en = 1'b0;
  endtask

  vec_t tbl [6];
  int hits;
  logic [31:0] held;

  initial begin
    tbl[0] = '{7'd0,   16, 0,  0};
    tbl[1] = '{7'd1,   17, 1,  0};
    tbl[2] = '{7'd5,   21, 5,  4};
    tbl[3] = '{7'd64,  80, 64, 63};
    tbl[4] = '{7'd100, 80, 64, 63};
    tbl[5] = '{7'd127, 80, 64, 63};

    bus.load_en = 0; bus.load_addr = 0; bus.load_data = 0;
    bus.load_hold = 0; bus.prog_len = 0; bus.start = 0;
    bus.abort = 0;

    repeat (3) @(posedge clock);
    #1;
    check_obs("reset", sample(), mk(0, NOP, 0, 0, 0, 0, 0), 1);
    reset = 1'b1;
    tick();
    check_obs("idle", sample(), mk(0, NOP, 0, 0, 0, 0, 0), 1);

    // Basic two-entry program
    load(0, 32'h4022_000F, 4'd0);
    load(1, 32'h4043_000F, 4'd4);
    run_prog(7'd2, -1, -1, 0, 0, 0);
    check_val("basic_rst_low",
              {obs[0].crn, obs[1].crn, obs[2].crn, obs[3].crn,
               obs[4].crn}, 5'b00001);
    check_val("basic_e0",
              {obs[4].inst, obs[4].valid, obs[4].idx},
              {32'h4022_000F, 1'b1, 6'd0});
    hits = 0;
    for (int k = 5; k <= 9; k++)
      if (obs[k].inst == 32'h4043_000F && obs[k].valid && obs[k].idx == 1)
        hits++;
    check_val("basic_e1_cycles", hits, 5);
    check_val("basic_drain", {obs[10].valid, obs[10].inst}, 33'h0);
    check_val("basic_done", {obs[25].done, obs[26].done}, 2'b01);
    check_val("basic_cnt", obs[26].cnt, 22);

    // Table vectors over a zero-hold program
    for (int i = 0; i < DEPTH; i++) load(i, $urandom, 4'd0);
    for (int t = 0; t < 6; t++) begin
      run_prog(tbl[t].plen, -1, -1, 0, 0, 0);
      check_val($sformatf("tbl%0d_cnt", t), last_cnt, tbl[t].cnt);
      check_val($sformatf("tbl%0d_nvalid", t), n_valid, tbl[t].nvalid);
      check_val($sformatf("tbl%0d_maxidx", t), max_idx, tbl[t].maxidx);
    end

    // Stray start and load while busy, then re-run
    run_prog(7'd5, 8, 6, 0, 0, 0);
    run_prog(7'd5, -1, -1, 0, 0, 0);

    // Abort in the third ISSUE cycle
    bus.prog_len = 7'd5;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (6) tick();
    check_val("abort_pre", {bus.inst_valid, bus.busy}, 2'b11);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_val("abort_state",
              {bus.core_reset_n, bus.inst_valid, bus.busy, bus.done,
               bus.inst_o}, 36'h0);
    held = bus.cycle_cnt;
    repeat (3) tick();
    check_val("abort_cnt_frozen", bus.cycle_cnt, held);
    check_val("abort_stays_idle", {bus.busy, bus.done}, 2'b00);
    run_prog(7'd3, -1, -1, 0, 0, 0);

    // Async reset in the middle of ISSUE
    bus.prog_len = 7'd5;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    #2 reset = 1'b0;
    #1;
    check_obs("async_reset", sample(), mk(0, NOP, 0, 0, 0, 0, 0), 1);
    #3 reset = 1'b1;
    tick();
    check_obs("post_reset_idle", sample(),
              mk(0, NOP, 0, 0, 0, 0, 0), 1);

    // Start and abort on the same edge
    bus.prog_len = 7'd5;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check_val("start_abort", {bus.busy, bus.core_reset_n}, 2'b00);
    tick();
    check_val("start_abort_hold", {bus.busy, bus.done}, 2'b00);

    run_prog(7'd5, -1, -1, 0, 0, 0);

    // Load and start on the same edge
    run_prog(7'd3, -1, -1, 1, 32'h1234_5678, 4'd2);
    check_val("load_start_first", obs[4].inst, 32'h1234_5678);

    // Randomised programs against the trace model
    for (int i = 0; i < 12; i++)
      load(i, $urandom, 4'($urandom_range(0, 15)));
    for (int r = 0; r < 6; r++)
      run_prog(7'($urandom_range(0, 12)), -1, -1, 0, 0, 0);
    run_prog(7'($urandom_range(65, 127)), -1, -1, 0, 0, 0);
    check_val("rand_clamp_maxidx", max_idx, 63);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
